// File: rtl/div_unit_pkg.sv
// Shared core definitions: divider op encodings (also decoded by the instruction decoder)
// and the divider FSM state type.
package div_unit_pkg;

  typedef enum logic [1:0] {
    OpDiv  = 2'b00,
    OpDivu = 2'b01,
    OpRem  = 2'b10,
    OpRemu = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StDone = 2'b10
  } div_state_e;

  function automatic logic is_signed_op(input div_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_rem_op(input div_op_e op);
    return (op == OpRem) || (op == OpRemu);
  endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed overflow resolved without iterating.
module div_unit
  import div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [1:0]            op_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  input  logic                  flush_i,
  output logic                  busy_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;

  // acc holds {partial remainder (W+1 bits), dividend/quotient shift field (W bits)}.
  function automatic logic [2*W:0] div_step(input logic [2*W:0] acc, input logic [W:0] dvs);
    logic [W+1:0] trial;
    logic [W-1:0] quo;
    trial = acc[2*W:W-1];
    quo   = {acc[W-2:0], 1'b0};
    if (trial >= {1'b0, dvs}) begin
      trial  = trial - {1'b0, dvs};
      quo[0] = 1'b1;
    end
    return {trial[W:0], quo};
  endfunction

  function automatic logic [W-1:0] apply_sign(input logic [W:0] mag, input logic neg);
    logic [W:0] v;
    v = neg ? (~mag + 1'b1) : mag;
    return v[W-1:0];
  endfunction

  div_state_e      state_q, state_d;
  div_op_e         op_q, op_d;
  logic [2*W:0]    acc_q, acc_d;
  logic [W:0]      dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [W-1:0]    result_q, result_d;
  logic            valid_q, valid_d;

  div_op_e    op_in;
  logic       signed_op, dvd_neg, dvs_neg, div_zero, overflow;
  logic [W:0] dvd_sx, dvs_sx, dvd_abs, dvs_abs;

  always_comb begin
    op_in     = div_op_e'(op_i);
    signed_op = is_signed_op(op_in);
    dvd_neg   = signed_op & dividend_i[W-1];
    dvs_neg   = signed_op & divisor_i[W-1];
    // Sign-extend into W+1 bits so the most-negative value negates without overflow.
    dvd_sx    = {dvd_neg, dividend_i};
    dvs_sx    = {dvs_neg, divisor_i};
    dvd_abs   = dvd_neg ? (~dvd_sx + 1'b1) : dvd_sx;
    dvs_abs   = dvs_neg ? (~dvs_sx + 1'b1) : dvs_sx;
    div_zero  = (divisor_i == '0);
    overflow  = signed_op && (dividend_i == {1'b1, {(W-1){1'b0}}}) && (divisor_i == '1);
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    result_d = result_q;
    valid_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !flush_i) begin
          op_d  = op_in;
          dvs_d = dvs_abs;
          cnt_d = '0;
          if (div_zero) begin
            // Quotient field all ones, remainder field the raw dividend, no sign fix-up.
            acc_d   = {1'b0, dividend_i, {W{1'b1}}};
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StDone;
          end else if (overflow) begin
            acc_d   = {{(W+1){1'b0}}, 1'b1, {(W-1){1'b0}}};
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = StDone;
          end else begin
            acc_d   = {{W{1'b0}}, dvd_abs};
            q_neg_d = dvd_neg ^ dvs_neg;
            r_neg_d = dvd_neg;
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        if (flush_i) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          acc_d = div_step(acc_q, dvs_q);
          if (cnt_q == CntW'(W - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        if (!flush_i) begin
          valid_d  = 1'b1;
          result_d = is_rem_op(op_q) ? apply_sign(acc_q[2*W:W], r_neg_q)
                                     : apply_sign({1'b0, acc_q[W-1:0]}, q_neg_q);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      op_q     <= OpDiv;
      acc_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  // Combinational from state so the hazard unit can stall in the same cycle.
  assign busy_o   = (state_q != StIdle);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand and result width; legal values are even and at least 4.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit: request a division; sampled only in IDLE.
REQ-005 SHALL have port op_i, input, 2 bits: div_op_e; DIV=00, DIVU=01, REM=10, REMU=11.
REQ-006 SHALL have port dividend_i, input, DATA_WIDTH bits: rs1 value, captured when start is accepted.
REQ-007 SHALL have port divisor_i, input, DATA_WIDTH bits: rs2 value, captured when start is accepted.
REQ-008 SHALL have port flush_i, input, 1 bit: abort any operation in progress.
REQ-009 SHALL have port busy_o, output, 1 bit: high while in CALC or DONE.
REQ-010 SHALL have port valid_o, output, 1 bit: one-cycle pulse marking result_o as new.
REQ-011 SHALL have port result_o, output, DATA_WIDTH bits: quotient or remainder; drives the writeback 4:1 select data3 input.

Function
REQ-012 SHALL implement an FSM with states IDLE, CALC and DONE.
REQ-013 SHALL accept start only when in IDLE with start_i=1 and flush_i=0; otherwise start_i is ignored, including while busy.
REQ-014 SHALL, on acceptance, capture op_i, the operand magnitudes (absolute values for DIV/REM) and the quotient and remainder signs.
REQ-015 SHALL set quotient sign = dividend sign XOR divisor sign and remainder sign = dividend sign.
REQ-016 SHALL perform restoring division in CALC, one quotient bit per cycle, MSB first, for exactly DATA_WIDTH cycles, driven by a bit counter of width $clog2(DATA_WIDTH)+1.
REQ-017 SHALL, after the last CALC cycle, enter DONE for one cycle, apply sign correction, register result_o and pulse valid_o; the next state is IDLE.
REQ-018 SHALL give normal latency as follows: start accepted at edge T gives valid_o high in the cycle following edge T+DATA_WIDTH+1.
REQ-019 SHALL handle divisor==0 by skipping CALC and going IDLE->DONE: DIV/DIVU result is all ones; REM/REMU result is the dividend unchanged.
REQ-020 SHALL handle signed overflow (DIV/REM, dividend = most-negative, divisor = -1) by skipping CALC: DIV result is the most-negative value; REM result is 0.
REQ-021 SHALL give special cases (REQ-019, REQ-020) valid_o high in the cycle following edge T+1.
REQ-022 SHALL compute the absolute value of the most-negative operand as its unsigned magnitude, with no overflow, using DATA_WIDTH+1-bit internal arithmetic.
REQ-023 SHALL hold result_o stable after DONE until the next DONE; valid_o is 0 outside DONE.
REQ-024 SHALL, when flush_i=1 in any state, return to IDLE at the next edge with valid_o=0 and result_o unchanged; if flush_i and start_i are both high in IDLE, no start is accepted.
REQ-025 SHALL, if start_i=1 in the DONE cycle, ignore it; a new start can be accepted one cycle after valid_o.

Reset
REQ-026 SHALL, on rst_i assertion, immediately force FSM=IDLE, counter=0, busy_o=0, valid_o=0, result_o=0 and clear all operand and partial registers, asynchronously and mid-operation included.
REQ-027 SHALL, after rst_i deassertion, accept start_i at the first rising edge.

Structure
REQ-028 SHALL place the div_op_e typedef and the op encodings in the shared core package, with the decoder as its other user.
REQ-029 SHALL define no sub-module; the single-bit restoring step is a function inside div_unit.
REQ-030 SHALL keep busy_o combinational from state only, so that the hazard unit can stall on it in the same cycle.

Verification
REQ-031 SHALL verify DIVU: 100 / 7 -> result 14, valid_o at T+DATA_WIDTH+1 (T+33 at default); REMU with the same operands -> 2.
REQ-032 SHALL verify DIV: -20 / 3 -> 0xFFFFFFFA (-6); REM with the same operands -> 0xFFFFFFFE (-2).
REQ-033 SHALL verify divide by zero: DIV 0x12345678 / 0 -> 0xFFFFFFFF, valid at T+1; REMU 0x12345678 / 0 -> 0x12345678.
REQ-034 SHALL verify overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0, valid at T+1.
REQ-035 SHALL verify flush at CALC cycle 10: no valid_o, busy_o=0 the next cycle, result_o unchanged; a new DIVU 9/3 then gives 3.
REQ-036 SHALL verify rst_i mid-CALC: outputs are 0 immediately; start_i held high during busy gives exactly one valid_o per accepted start.
